// File: rtl/fwd_hazard_ctrl.sv
// Operand-forward selects and load-use/redirect hazard control for an in-order F/D/X/M/W pipe.
// Selects and lu_cnt are registered one cycle after D; stall/bubble/flush are combinational; mem_stall freezes everything.
module fwd_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_D,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic        use_rs1_D,
    input  logic        use_rs2_D,
    input  logic [4:0]  rd_D,
    input  logic        we_D,
    input  logic        load_D,
    input  logic        redirect_X,
    input  logic        mem_stall,
    output logic [1:0]  rs1_sel,
    output logic [1:0]  rs2_sel,
    output logic        stall_FD,
    output logic        bubble_X,
    output logic        flush_D,
    output logic [15:0] lu_cnt
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } stage_rec_t;

    stage_rec_t rec_d, rec_x, rec_m, rec_w;
    logic       x_prod, m_prod, load_use;
    logic [1:0] rs1_nxt, rs2_nxt;

    assign rec_d = stage_rec_t'{valid: valid_D, rd: rd_D, we: we_D, load: load_D};

    // x0 is hard-wired zero, so a write to it is never a forwarding source.
    assign x_prod = rec_x.valid && rec_x.we && (rec_x.rd != 5'd0);
    assign m_prod = rec_m.valid && rec_m.we && (rec_m.rd != 5'd0);

    assign load_use = valid_D && x_prod && rec_x.load &&
                      ((use_rs1_D && (rs1_D == rec_x.rd)) || (use_rs2_D && (rs2_D == rec_x.rd)));

    // Redirect wins over load-use: the dependent instruction is being flushed anyway.
    assign stall_FD = mem_stall || (load_use && !redirect_X);
    assign bubble_X = !mem_stall && (redirect_X || load_use);
    assign flush_D  = !mem_stall && redirect_X;

    // A producer now in X will sit in M when the reader reaches X (sel 1); one now in M will be in W (sel 2).
    always_comb begin
        rs1_nxt = 2'd0;
        rs2_nxt = 2'd0;
        if (valid_D && !bubble_X) begin
            if (use_rs1_D) begin
                if (x_prod && !rec_x.load && (rs1_D == rec_x.rd))
                    rs1_nxt = 2'd1;
                else if (m_prod && (rs1_D == rec_m.rd))
                    rs1_nxt = 2'd2;
            end
            if (use_rs2_D) begin
                if (x_prod && !rec_x.load && (rs2_D == rec_x.rd))
                    rs2_nxt = 2'd1;
                else if (m_prod && (rs2_D == rec_m.rd))
                    rs2_nxt = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_x   <= '0;
            rec_m   <= '0;
            rec_w   <= '0;
            rs1_sel <= 2'd0;
            rs2_sel <= 2'd0;
            lu_cnt  <= 16'd0;
        end else if (!mem_stall) begin
            rec_w   <= rec_m;
            rec_m   <= rec_x;
            rec_x   <= bubble_X ? stage_rec_t'('0) : rec_d;
            rs1_sel <= rs1_nxt;
            rs2_sel <= rs2_nxt;
            if (load_use && !redirect_X && (lu_cnt != 16'hFFFF))
                lu_cnt <= lu_cnt + 16'd1;
        end
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: valid_D  in  1  D-stage slot holds a real instruction; rs1_D, rs2_D  in  5 each  D-stage source indices; use_rs1_D, use_rs2_D  in  1 each  the D-stage instruction reads that source.
REQ-003 SHALL have ports: rd_D  in  5  D-stage destination; we_D  in  1  D-stage writes rd; load_D  in  1  D-stage instruction is a load.
REQ-004 SHALL have ports: redirect_X  in  1  taken branch or jump resolved in X; mem_stall  in  1  data memory not ready, freeze the whole pipe.
REQ-005 SHALL have ports: rs1_sel, rs2_sel  out  2 each  registered X-stage operand select (0 = regfile, 1 = rd_M, 2 = rd_W; 3 never driven); stall_FD  out  1  hold PC and the F/D register; bubble_X  out  1  load NOP into the D/X register; flush_D  out  1  invalidate the F/D register.
REQ-006 SHALL have port: lu_cnt  out  16  count of load-use bubbles, saturating.

Function
REQ-007 SHALL keep an internal stage record {valid, rd, we, load} for X, M and W, advancing X->M->W on every clk edge where mem_stall=0.
REQ-008 SHALL load the X record from the D inputs on an advancing edge; on a load-use stall or redirect_X, the X record SHALL instead be loaded invalid (bubble).
REQ-009 SHALL treat a record as a forwarding producer only when valid=1, we=1 and rd!=0; x0 SHALL never be forwarded.
REQ-010 SHALL compute next rsN_sel per source: 1 if it matches the current X record (non-load), else 2 if it matches the current M record, else 0; X match SHALL have priority over M match.
REQ-011 SHALL register rsN_sel on advancing edges, so the select presented in a cycle belongs to the instruction then in X; latency from D to select = 1 cycle.
REQ-012 SHALL force next rsN_sel to 0 when use_rsN_D=0, valid_D=0, a bubble is inserted, or redirect_X=1.
REQ-013 SHALL leave regfile write-then-read (W writing while D reads) to regfile bypass; this block SHALL NOT forward from records beyond M.
REQ-014 SHALL detect load-use when valid_D=1, the X record is valid, has load=1, we=1 and rd!=0, and rd equals a used D source.
REQ-015 On load-use (combinational, same cycle): stall_FD=1 and bubble_X=1 for exactly one cycle; the dependent instruction SHALL then receive rsN_sel=2 on the following advance.
REQ-016 On redirect_X=1: flush_D=1 and bubble_X=1, stall_FD=0; redirect SHALL override load-use detection in the same cycle, and lu_cnt SHALL NOT increment.
REQ-017 While mem_stall=1: stall_FD=1, bubble_X=0, flush_D=0, all records, selects and lu_cnt SHALL hold, and redirect_X and load-use SHALL be ignored (the upstream stage holds them until mem_stall drops).
REQ-018 lu_cnt SHALL increment by 1 on each advancing edge where a load-use bubble is inserted, saturating at 16'hFFFF.
REQ-019 stall_FD, bubble_X and flush_D SHALL be combinational from inputs and current records; rsN_sel and lu_cnt SHALL be registered.

Reset
REQ-020 rst_n=0 SHALL immediately clear all record valids, rs1_sel=rs2_sel=0 and lu_cnt=0, independent of clk.
REQ-021 Reset deassertion mid-stall SHALL resume with empty records: no stall or bubble until a load enters X.

Verification
REQ-022 ALU chain: add x5 (we, rd=5) then add rs1=5 -> dependent in X with rs1_sel=1, rs2_sel=0, no stall.
REQ-023 Distance two: add x7, unrelated instruction, then reader rs2=7 -> rs2_sel=2; reader of x0 after a write to x0 -> sel=0.
REQ-024 Load-use: lw x3 in X, D reads rs1=3 -> stall_FD=1, bubble_X=1 for one cycle, lu_cnt 0->1, next cycle the reader in X has rs1_sel=2.
REQ-025 Redirect plus load-use in the same cycle -> flush_D=1, bubble_X=1, stall_FD=0, lu_cnt unchanged, next rs*_sel=0.
REQ-026 mem_stall high for 3 cycles with forwarding pending -> selects, records and lu_cnt frozen; forwarding resumes correctly afterwards; rst_n low mid-sequence -> all outputs 0 at once; lu_cnt forced to FFFF stays FFFF on a further bubble.
